tenant_demux: RTL and testbench
===============================

Name: tenant_demux

Overview:
- Single-input, NUM_QUEUES-output AXI4-Stream packet demultiplexer.
- Sits at the front of the multi-tenant pipeline. It steers each packet to the per-tenant user pipeline whose merged outputs feed the round-robin output mux.
- The tenant ID is taken from a tuser field on the first beat and held for the whole packet.
- Packets for a disabled or out-of-range tenant are dropped.
- One shared output register stage; latency 1 cycle; full-rate throughput when the selected port is ready.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, output tdata width.
- C_S_AXIS_DATA_WIDTH, 256, input tdata width (must equal C_M_AXIS_DATA_WIDTH).
- C_M_AXIS_TUSER_WIDTH, 128, output tuser width.
- C_S_AXIS_TUSER_WIDTH, 128, input tuser width.
- NUM_QUEUES, 4, number of tenant output ports (fixed at 4 by the port list).
- TENANT_LSB, 32, LSB of the tenant-ID field in s_axis_tuser.
- TENANT_WIDTH, 8, width of the tenant-ID field.

Ports:
- axis_aclk  in  1  clock.
- axis_resetn  in  1  asynchronous active-low reset.
- tenant_en  in  NUM_QUEUES  per-tenant enable; sampled only at SOP.
- s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  input data.
- s_axis_tkeep  in  C_S_AXIS_DATA_WIDTH/8  byte enables.
- s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  metadata; carries the tenant ID.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  end of packet.
- m_axis_k_tdata  out  C_M_AXIS_DATA_WIDTH  for k=0..3; shared data register.
- m_axis_k_tkeep  out  C_M_AXIS_DATA_WIDTH/8  for k=0..3; shared register.
- m_axis_k_tuser  out  C_M_AXIS_TUSER_WIDTH  for k=0..3; shared register, forwarded unmodified.
- m_axis_k_tvalid  out  1  for k=0..3; high only for the selected port.
- m_axis_k_tready  in  1  for k=0..3; per-port ready.
- m_axis_k_tlast  out  1  for k=0..3; shared register.

Behaviour:
- Reset: asynchronous, active-low. Clears state to IDLE, out_valid to 0, out_sel to 0 and the drop flag.
  - All m_axis_k_tvalid = 0 during and after reset.
  - Data registers are not reset.
- Reset mid-packet abandons the packet; downstream sees a truncated packet, which is accepted behaviour.
- Output stage: one register (data/keep/user/last, out_valid, out_sel).
  - m_axis_k_tvalid = out_valid & (out_sel==k).
  - Register contents are stable while m_axis_k_tvalid & ~m_axis_k_tready.
- Tenant decode at SOP: tid = s_axis_tuser[TENANT_LSB +: TENANT_WIDTH].
  - The packet is accepted if tid < NUM_QUEUES and tenant_en[tid] = 1; otherwise it is dropped.
- State machine, 3 states:
  - IDLE (next beat is SOP).
    - If tvalid and the packet is accepted: behave as FWD for this beat, with destination = tid.
    - If tvalid and the packet is dropped: behave as DROP for this beat.
    - After a non-last beat, go to FWD or DROP respectively.
    - A single-beat packet (tlast on SOP) stays in IDLE.
  - FWD: s_axis_tready = ~out_valid | m_axis_{out_sel}_tready.
    - On handshake, load the register, set out_valid=1 and out_sel=cur_dest.
    - tlast handshake → IDLE.
    - If no new beat is loaded and the downstream handshakes, clear out_valid.
  - DROP: s_axis_tready = 1; beats are discarded; the output register is untouched; tlast handshake → IDLE.
- In IDLE, s_axis_tready follows the rule of whichever state the SOP decodes to.
  - The decode is combinational on the current input beat.
- Head-of-line: a stalled port blocks all ports until its held beat drains. This is intentional; downstream FIFOs absorb the stall.
- Simultaneous drain of the held beat and load of a new beat to a different port in the same cycle is legal: out_sel switches and there is no bubble.
- A tenant_en change mid-packet has no effect until the next SOP.
- Back-to-back packets to different tenants: zero idle cycles required.

Optional Feature:
- TENANT_DEMUX_STATS_EN.
  - Defined: adds outputs pkt_cnt_k (32-bit, k=0..3) and drop_cnt (32-bit).
  - pkt_cnt_k increments on the tlast handshake of a forwarded packet to port k.
  - drop_cnt increments on the tlast handshake in DROP (or a single-beat drop).
  - Counters wrap at 2^32 and clear on reset.
  - Undefined: no counters or ports; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - the state encodings (IDLE, FWD, DROP);
  - the tuser field defaults TENANT_LSB and TENANT_WIDTH, shared with the tenant tagging logic upstream;
  - the log2 helper.
- One natural sub-module: tenant_demux_out_reg, the one-entry output register slice with valid/ready hold logic.

Test Plan:
- Back-to-back 3-beat packets, tid=0,1,2,3, all enabled, all ready=1 → each appears on port k after 1 cycle latency, with s_axis_tready continuously 1 and 12 beats in 12 cycles.
- tid=5, then tid=2 with tenant_en=4'b1011 → both packets dropped, s_axis_tready=1 throughout, no m_axis_k_tvalid asserted; drop_cnt=2 with STATS_EN.
- Packet to port 1 with m_axis_1_tready held low for 5 cycles mid-packet → port-1 outputs hold a stable beat, s_axis_tready=0, no beat loss or duplication, and the next packet to port 2 waits.
- Single-beat packets (tlast on SOP) alternating ports 0/3 → each delivered as one beat, state stays IDLE, no bubbles.
- tenant_en[0] cleared during the 2nd beat of a 4-beat packet to port 0 → all 4 beats delivered; the following packet to tid 0 is dropped.
- axis_resetn asserted asynchronously mid-packet → all tvalid drop to 0 immediately; after release, the next beat is treated as SOP and routed by its own tid.

Source files
------------

// File: rtl/tenant_demux_pkg.sv
// Shared definitions for the tenant demultiplexer: FSM encodings, tenant-ID
// field defaults (also used by the upstream tenant tagger) and a log2 helper.
package tenant_demux_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      DROP = 2'd2
   } state_t;

   localparam int TENANT_LSB_DEF   = 32;
   localparam int TENANT_WIDTH_DEF = 8;

   // Ceiling log2, used to size port-select fields.
   function automatic int log2c(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/tenant_demux_out_reg.sv
// One-entry output register slice shared by all tenant ports; holds a beat
// until the selected port accepts it. Payload registers carry no reset.
module tenant_demux_out_reg
   import tenant_demux_pkg::*;
#(
   parameter int DATA_W = 256,
   parameter int KEEP_W = 32,
   parameter int USER_W = 128,
   parameter int SEL_W  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [SEL_W-1:0]  load_sel,
   input  logic              drain,
   input  logic [DATA_W-1:0] in_data,
   input  logic [KEEP_W-1:0] in_keep,
   input  logic [USER_W-1:0] in_user,
   input  logic              in_last,
   output logic              out_valid,
   output logic [SEL_W-1:0]  out_sel,
   output logic [DATA_W-1:0] out_data,
   output logic [KEEP_W-1:0] out_keep,
   output logic [USER_W-1:0] out_user,
   output logic              out_last
);

   // A load replaces a draining beat in the same cycle, so no bubble appears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sel   <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_sel   <= load_sel;
      end else if (drain) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         out_data <= in_data;
         out_keep <= in_keep;
         out_user <= in_user;
         out_last <= in_last;
      end
   end

endmodule

// File: rtl/tenant_demux.sv
// AXI4-Stream 1-to-4 tenant demultiplexer; tenant ID taken from tuser at SOP.
// Optional counters enabled with `define TENANT_DEMUX_STATS_EN.
module tenant_demux
   import tenant_demux_pkg::*;
#(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int NUM_QUEUES           = 4,
   parameter int TENANT_LSB           = TENANT_LSB_DEF,
   parameter int TENANT_WIDTH         = TENANT_WIDTH_DEF
) (
   input  logic                              axis_aclk,
   input  logic                              axis_resetn,
   input  logic [NUM_QUEUES-1:0]             tenant_en,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic                              s_axis_tlast,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_0_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_0_tkeep,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_0_tuser,
   output logic                              m_axis_0_tvalid,
   input  logic                              m_axis_0_tready,
   output logic                              m_axis_0_tlast,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_1_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_1_tkeep,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_1_tuser,
   output logic                              m_axis_1_tvalid,
   input  logic                              m_axis_1_tready,
   output logic                              m_axis_1_tlast,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_2_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_2_tkeep,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_2_tuser,
   output logic                              m_axis_2_tvalid,
   input  logic                              m_axis_2_tready,
   output logic                              m_axis_2_tlast,
`ifdef TENANT_DEMUX_STATS_EN
   output logic [31:0]                       pkt_cnt_0,
   output logic [31:0]                       pkt_cnt_1,
   output logic [31:0]                       pkt_cnt_2,
   output logic [31:0]                       pkt_cnt_3,
   output logic [31:0]                       drop_cnt,
`endif
   output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_3_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_3_tkeep,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_3_tuser,
   output logic                              m_axis_3_tvalid,
   input  logic                              m_axis_3_tready,
   output logic                              m_axis_3_tlast
);

   localparam int SEL_W  = log2c(NUM_QUEUES);
   localparam int KEEP_W = C_M_AXIS_DATA_WIDTH / 8;
   localparam logic [TENANT_WIDTH-1:0] TID_LIMIT = TENANT_WIDTH'(NUM_QUEUES);

   state_t                          state;
   logic [SEL_W-1:0]                cur_dest;
   logic [SEL_W-1:0]                dest;
   logic [SEL_W-1:0]                out_sel;
   logic                            out_valid;
   logic [NUM_QUEUES-1:0]           m_ready;
   logic [NUM_QUEUES-1:0]           m_valid;
   logic [TENANT_WIDTH-1:0]         tid;
   logic                            accept;
   logic                            fwd_beat;
   logic                            sel_ready;
   logic                            can_load;
   logic                            hs;
   logic                            load;
   logic                            drain;
   logic [C_M_AXIS_DATA_WIDTH-1:0]  out_data;
   logic [KEEP_W-1:0]               out_keep;
   logic [C_M_AXIS_TUSER_WIDTH-1:0] out_user;
   logic                            out_last;

   assign m_ready = {m_axis_3_tready, m_axis_2_tready, m_axis_1_tready, m_axis_0_tready};

   // In IDLE the current beat is the SOP, so routing is decoded from it directly.
   assign tid       = s_axis_tuser[TENANT_LSB +: TENANT_WIDTH];
   assign accept    = (tid < TID_LIMIT) && tenant_en[tid[SEL_W-1:0]];
   assign fwd_beat  = (state == FWD) || ((state == IDLE) && accept);
   assign dest      = (state == IDLE) ? tid[SEL_W-1:0] : cur_dest;
   assign sel_ready = m_ready[out_sel];
   assign can_load  = !out_valid || sel_ready;

   assign s_axis_tready = !fwd_beat || can_load;
   assign hs            = s_axis_tvalid && s_axis_tready;
   assign load          = hs && fwd_beat;
   assign drain         = out_valid && sel_ready;

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         state    <= IDLE;
         cur_dest <= '0;
      end else if (hs) begin
         if (s_axis_tlast) begin
            state <= IDLE;
         end else if (state == IDLE) begin
            state    <= accept ? FWD : DROP;
            cur_dest <= tid[SEL_W-1:0];
         end
      end
   end

   tenant_demux_out_reg #(
      .DATA_W (C_M_AXIS_DATA_WIDTH),
      .KEEP_W (KEEP_W),
      .USER_W (C_M_AXIS_TUSER_WIDTH),
      .SEL_W  (SEL_W)
   ) u_out_reg (
      .clk       (axis_aclk),
      .rst_n     (axis_resetn),
      .load      (load),
      .load_sel  (dest),
      .drain     (drain),
      .in_data   (s_axis_tdata),
      .in_keep   (s_axis_tkeep),
      .in_user   (s_axis_tuser),
      .in_last   (s_axis_tlast),
      .out_valid (out_valid),
      .out_sel   (out_sel),
      .out_data  (out_data),
      .out_keep  (out_keep),
      .out_user  (out_user),
      .out_last  (out_last)
   );

   for (genvar k = 0; k < NUM_QUEUES; k++) begin : g_valid
      assign m_valid[k] = out_valid && (out_sel == SEL_W'(k));
   end

   assign m_axis_0_tvalid = m_valid[0];
   assign m_axis_1_tvalid = m_valid[1];
   assign m_axis_2_tvalid = m_valid[2];
   assign m_axis_3_tvalid = m_valid[3];

   assign m_axis_0_tdata = out_data;
   assign m_axis_1_tdata = out_data;
   assign m_axis_2_tdata = out_data;
   assign m_axis_3_tdata = out_data;
   assign m_axis_0_tkeep = out_keep;
   assign m_axis_1_tkeep = out_keep;
   assign m_axis_2_tkeep = out_keep;
   assign m_axis_3_tkeep = out_keep;
   assign m_axis_0_tuser = out_user;
   assign m_axis_1_tuser = out_user;
   assign m_axis_2_tuser = out_user;
   assign m_axis_3_tuser = out_user;
   assign m_axis_0_tlast = out_last;
   assign m_axis_1_tlast = out_last;
   assign m_axis_2_tlast = out_last;
   assign m_axis_3_tlast = out_last;

`ifdef TENANT_DEMUX_STATS_EN
   logic [31:0] pkt_cnt_r [NUM_QUEUES];
   logic [31:0] drop_cnt_r;

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         for (int k = 0; k < NUM_QUEUES; k++) pkt_cnt_r[k] <= '0;
         drop_cnt_r <= '0;
      end else if (hs && s_axis_tlast) begin
         if (fwd_beat) pkt_cnt_r[dest] <= pkt_cnt_r[dest] + 32'd1;
         else          drop_cnt_r      <= drop_cnt_r + 32'd1;
      end
   end

   assign pkt_cnt_0 = pkt_cnt_r[0];
   assign pkt_cnt_1 = pkt_cnt_r[1];
   assign pkt_cnt_2 = pkt_cnt_r[2];
   assign pkt_cnt_3 = pkt_cnt_r[3];
   assign drop_cnt  = drop_cnt_r;
`endif

endmodule

// File: tb/tb_tenant_demux.sv
// Directed bench for tenant_demux with an in-order scoreboard of forwarded beats.
module tb_tenant_demux;

   logic         clk = 1'b0;
   logic         axis_resetn;
   logic [3:0]   tenant_en;
   logic [255:0] s_axis_tdata;
   logic [31:0]  s_axis_tkeep;
   logic [127:0] s_axis_tuser;
   logic         s_axis_tvalid;
   logic         s_axis_tready;
   logic         s_axis_tlast;
   logic [3:0]   mrdy;
   logic [3:0]   mv;
   logic [255:0] od [4];
   logic [31:0]  ok [4];
   logic [127:0] ou [4];
   logic         ol [4];
`ifdef TENANT_DEMUX_STATS_EN
   logic [31:0]  pkt_cnt_0, pkt_cnt_1, pkt_cnt_2, pkt_cnt_3, drop_cnt;
`endif

   always #5 clk = ~clk;

   tenant_demux dut (
      .axis_aclk       (clk),
      .axis_resetn     (axis_resetn),
      .tenant_en       (tenant_en),
      .s_axis_tdata    (s_axis_tdata),
      .s_axis_tkeep    (s_axis_tkeep),
      .s_axis_tuser    (s_axis_tuser),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tready   (s_axis_tready),
      .s_axis_tlast    (s_axis_tlast),
      .m_axis_0_tdata  (od[0]),
      .m_axis_0_tkeep  (ok[0]),
      .m_axis_0_tuser  (ou[0]),
      .m_axis_0_tvalid (mv[0]),
      .m_axis_0_tready (mrdy[0]),
      .m_axis_0_tlast  (ol[0]),
      .m_axis_1_tdata  (od[1]),
      .m_axis_1_tkeep  (ok[1]),
      .m_axis_1_tuser  (ou[1]),
      .m_axis_1_tvalid (mv[1]),
      .m_axis_1_tready (mrdy[1]),
      .m_axis_1_tlast  (ol[1]),
      .m_axis_2_tdata  (od[2]),
      .m_axis_2_tkeep  (ok[2]),
      .m_axis_2_tuser  (ou[2]),
      .m_axis_2_tvalid (mv[2]),
      .m_axis_2_tready (mrdy[2]),
      .m_axis_2_tlast  (ol[2]),
`ifdef TENANT_DEMUX_STATS_EN
      .pkt_cnt_0       (pkt_cnt_0),
      .pkt_cnt_1       (pkt_cnt_1),
      .pkt_cnt_2       (pkt_cnt_2),
      .pkt_cnt_3       (pkt_cnt_3),
      .drop_cnt        (drop_cnt),
`endif
      .m_axis_3_tdata  (od[3]),
      .m_axis_3_tkeep  (ok[3]),
      .m_axis_3_tuser  (ou[3]),
      .m_axis_3_tvalid (mv[3]),
      .m_axis_3_tready (mrdy[3]),
      .m_axis_3_tlast  (ol[3])
   );

   typedef struct {
      int           port;
      logic [255:0] data;
      logic [31:0]  keep;
      logic [127:0] user;
      logic         last;
      int           cyc;
      bit           lat;
   } exp_t;

   exp_t         sb[$];
   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   int           out_beats = 0;
   int           stalls = 0;
   int           beat_id = 0;
   bit           lat_on = 0;
   bit           prev_hold = 0;
   logic [255:0] prev_data;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Output monitor: pops the scoreboard on every output handshake.
   always @(negedge clk) begin
      exp_t e;
      if (axis_resetn) begin
         if (mv != 4'd0) chk("onehot_valid", 256'($countones(mv) == 1), 256'd1);
         if (prev_hold) chk("hold_stable", od[0], prev_data);
         for (int k = 0; k < 4; k++) begin
            if (mv[k] && mrdy[k]) begin
               out_beats++;
               if (sb.size() == 0) begin
                  chk("unexpected_beat", 256'(sb.size()), 256'd1);
               end else begin
                  e = sb.pop_front();
                  chk("port", 256'(k), 256'(e.port));
                  chk("data", od[k], e.data);
                  chk("keep", 256'(ok[k]), 256'(e.keep));
                  chk("user", 256'(ou[k]), 256'(e.user));
                  chk("last", 256'(ol[k]), 256'(e.last));
                  if (e.lat) chk("latency", 256'(cyc - e.cyc), 256'd1);
               end
            end
         end
         prev_hold = |(mv & ~mrdy);
         prev_data = od[0];
      end else begin
         prev_hold = 0;
      end
   end

   // Sends a packet; stop_at >= 0 abandons it after that many beats.
   task automatic send_pkt(input int tid, input int n, input int clr_at, input int stop_at);
      bit           fwd;
      bit           hs;
      int           w;
      logic [127:0] u;
      exp_t         e;
      fwd = (tid < 4) ? tenant_en[tid[1:0]] : 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i == stop_at) break;
         if (i == clr_at) tenant_en[0] = 1'b0;
         beat_id++;
         u = '0;
         u[31:0]   = beat_id;
         u[39:32]  = tid[7:0];
         u[127:96] = ~beat_id;
         s_axis_tdata  = {8{beat_id}};
         s_axis_tkeep  = beat_id ^ 32'hA5A5_0F0F;
         s_axis_tuser  = u;
         s_axis_tlast  = (i == n - 1);
         s_axis_tvalid = 1'b1;
         w = 0;
         do begin
            @(negedge clk);
            hs = s_axis_tready;
            if (!hs) stalls++;
            if (hs && fwd) begin
               e.port = tid; e.data = s_axis_tdata; e.keep = s_axis_tkeep;
               e.user = s_axis_tuser; e.last = s_axis_tlast; e.cyc = cyc; e.lat = lat_on;
               sb.push_back(e);
            end
            @(posedge clk);
            #1;
            w++;
         end while (!hs && w < 200);
         if (!hs) chk("hs_timeout", 256'(hs), 256'd1);
      end
      s_axis_tvalid = 1'b0;
   endtask

   task automatic drain_sb();
      repeat (6) @(posedge clk);
      #1;
      chk("sb_empty", 256'(sb.size()), 256'd0);
   endtask

   initial begin
      int c0, ob0, st0;
      axis_resetn   = 1'b0;
      tenant_en     = 4'hF;
      mrdy          = 4'hF;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tuser  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", 256'(mv), 256'd0);
      axis_resetn = 1'b1;
      @(posedge clk);
      #1;
      chk("post_reset_valid", 256'(mv), 256'd0);

      // back-to-back 3-beat packets to every tenant
      lat_on = 1;
      c0 = cyc; st0 = stalls; ob0 = out_beats;
      for (int t = 0; t < 4; t++) send_pkt(t, 3, -1, -1);
      chk("b2b_cycles", 256'(cyc - c0), 256'd12);
      chk("b2b_no_stall", 256'(stalls), 256'(st0));
      drain_sb();
      chk("b2b_beats", 256'(out_beats - ob0), 256'd12);

      // out-of-range and disabled tenants are dropped
      tenant_en = 4'b1011;
      ob0 = out_beats; st0 = stalls;
      send_pkt(5, 3, -1, -1);
      send_pkt(2, 2, -1, -1);
      drain_sb();
      chk("drop_no_out", 256'(out_beats), 256'(ob0));
      chk("drop_tready", 256'(stalls), 256'(st0));
`ifdef TENANT_DEMUX_STATS_EN
      chk("drop_cnt_2", 256'(drop_cnt), 256'd2);
`endif
      tenant_en = 4'hF;

      // port-1 stall mid-packet, then a packet to port 2 queued behind it
      lat_on = 0;
      ob0 = out_beats;
      fork
         begin
            @(posedge clk);
            #2 mrdy[1] = 1'b0;
            repeat (2) @(negedge clk);
            chk("stall_tready", 256'(s_axis_tready), 256'd0);
            chk("stall_valid1", 256'(mv[1]), 256'd1);
            repeat (3) @(posedge clk);
            #2 mrdy[1] = 1'b1;
         end
      join_none
      send_pkt(1, 4, -1, -1);
      send_pkt(2, 2, -1, -1);
      drain_sb();
      chk("stall_beats", 256'(out_beats - ob0), 256'd6);

      // single-beat packets alternating ports 0 and 3
      lat_on = 1;
      c0 = cyc; st0 = stalls;
      send_pkt(0, 1, -1, -1);
      send_pkt(3, 1, -1, -1);
      send_pkt(0, 1, -1, -1);
      send_pkt(3, 1, -1, -1);
      chk("single_cycles", 256'(cyc - c0), 256'd4);
      chk("single_no_stall", 256'(stalls), 256'(st0));
      drain_sb();

      // tenant 0 disabled mid-packet: current packet completes, next one drops
      ob0 = out_beats;
      send_pkt(0, 4, 1, -1);
      send_pkt(0, 2, -1, -1);
      drain_sb();
      chk("en_change_beats", 256'(out_beats - ob0), 256'd4);
`ifdef TENANT_DEMUX_STATS_EN
      chk("drop_cnt_3", 256'(drop_cnt), 256'd3);
      chk("pkt_cnt_0", 256'(pkt_cnt_0), 256'd4);
`endif
      tenant_en = 4'hF;

      // asynchronous reset with a beat held on port 2
      lat_on = 0;
      mrdy = 4'b1011;
      send_pkt(2, 4, -1, 1);
      chk("pre_rst_valid2", 256'(mv[2]), 256'd1);
      #3 axis_resetn = 1'b0;
      #1;
      chk("rst_async_valid", 256'(mv), 256'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      axis_resetn = 1'b1;
      mrdy = 4'hF;
      ob0 = out_beats;
      send_pkt(3, 2, -1, -1);
      drain_sb();
      chk("post_rst_beats", 256'(out_beats - ob0), 256'd2);
`ifdef TENANT_DEMUX_STATS_EN
      chk("pkt_cnt_3_after_rst", 256'(pkt_cnt_3), 256'd1);
      chk("drop_cnt_after_rst", 256'(drop_cnt), 256'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
